// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller states, scoreboard entry layout and the producer/consumer
// match helper used by the scoreboard.
package pipe_ctrl_pkg;

  localparam int REG_W = 4;

  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    HALT_DRAIN,
    HALTED
  } state_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    logic regwrite;
    logic memread;
  } sb_entry_t;

  // An in-flight instruction produces a value a source needs. R0 is
  // hard-wired to zero, so it never counts as a dependency.
  function automatic logic sb_match(sb_entry_t e, reg_t src);
    return e.valid & e.regwrite & (e.rd == src) & (src != '0);
  endfunction

  // The younger producer (MEM stage) holds the newer value, so it wins.
  function automatic fwd_sel_t fwd_pick(logic mem_hit, logic wb_hit);
    if (mem_hit) return FWD_EXMEM;
    if (wb_hit)  return FWD_MEMWB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = datapath side (drives ID/EX status), slave = controller.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic     id_valid;
  reg_t     id_rs;
  reg_t     id_rt;
  logic     id_rs_used;
  logic     id_rt_used;
  reg_t     id_rd;
  logic     id_regwrite;
  logic     id_memread;
  logic     id_hlt;
  logic     ex_branch_taken;

  logic     stall_if;
  logic     stall_id;
  logic     flush_id;
  logic     flush_ex;
  fwd_sel_t fwd_a_sel;
  fwd_sel_t fwd_b_sel;
  logic     halted;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_regwrite, id_memread, id_hlt, ex_branch_taken,
    input  stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel,
           halted
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
           id_regwrite, id_memread, id_hlt, ex_branch_taken,
    output stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel,
           halted
  );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: shadows the EX, MEM and WB pipeline registers with
// just the destination information needed for hazard detection, and
// derives the stall request and forwarding selects from it.
// Build option PIPE_FWD_EN: enables forwarding (only load-use stalls);
// without it every EX/MEM producer stalls ID and forwarding stays off.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  sb_entry_t id_entry_i,
  input  reg_t      id_rs_i,
  input  reg_t      id_rt_i,
  input  logic      id_rs_need_i,
  input  logic      id_rt_need_i,
  input  logic      bubble_i,
  output logic      hazard_o,
  output fwd_sel_t  fwd_a_sel_o,
  output fwd_sel_t  fwd_b_sel_o
);

  sb_entry_t ex_q, ex_d, mem_q;

  // A stalled or flushed ID instruction must not enter EX, so it becomes a bubble
  always_comb begin
    ex_d = id_entry_i;
    if (bubble_i) ex_d.valid = 1'b0;
  end

  // Shift the destination shadow down the pipeline every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
    end
  end

`ifdef PIPE_FWD_EN
  sb_entry_t wb_q;
  reg_t      ex_rs_q, ex_rt_q;

  // WB shadow and EX source specifiers are only needed to steer forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q    <= '0;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else begin
      wb_q    <= mem_q;
      ex_rs_q <= id_rs_i;
      ex_rt_q <= id_rt_i;
    end
  end

  // Only a load in EX cannot be forwarded in time for the ID consumer
  always_comb begin
    hazard_o = ex_q.memread &
               ((id_rs_need_i & sb_match(ex_q, id_rs_i)) |
                (id_rt_need_i & sb_match(ex_q, id_rt_i)));
  end

  // Pick the newest producer of each EX operand
  always_comb begin
    fwd_a_sel_o = fwd_pick(sb_match(mem_q, ex_rs_q), sb_match(wb_q, ex_rs_q));
    fwd_b_sel_o = fwd_pick(sb_match(mem_q, ex_rt_q), sb_match(wb_q, ex_rt_q));
  end
`else
  // Without forwarding any EX or MEM producer must retire before ID reads;
  // a WB producer is fine because the register file writes first half-cycle
  always_comb begin
    hazard_o = (id_rs_need_i & (sb_match(ex_q, id_rs_i) | sb_match(mem_q, id_rs_i))) |
               (id_rt_need_i & (sb_match(ex_q, id_rt_i) | sb_match(mem_q, id_rt_i)));
  end

  assign fwd_a_sel_o = FWD_NONE;
  assign fwd_b_sel_o = FWD_NONE;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard controller for the 5-stage pipeline. Owns the
// RUN/LDSTALL/HALT_DRAIN/HALTED sequencing and decodes stall, flush and
// halt outputs; dependency tracking lives in hazard_scoreboard.
// Build option PIPE_FWD_EN selects forwarding vs. stall-only operation.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int               CNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sb_entry_t        id_entry;
  logic             hazard;
  logic             bubble;
  logic             stall_if;
  logic             stall_id;
  logic             flush;
  logic             halted;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;

  assign id_entry = '{valid:    bus.id_valid,
                      rd:       bus.id_rd,
                      regwrite: bus.id_regwrite,
                      memread:  bus.id_memread};

  assign bubble = stall_id | flush;

  hazard_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_entry_i   (id_entry),
    .id_rs_i      (bus.id_rs),
    .id_rt_i      (bus.id_rt),
    .id_rs_need_i (bus.id_valid & bus.id_rs_used),
    .id_rt_need_i (bus.id_valid & bus.id_rt_used),
    .bubble_i     (bubble),
    .hazard_o     (hazard),
    .fwd_a_sel_o  (fwd_a),
    .fwd_b_sel_o  (fwd_b)
  );

  // Controller state and drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and output decode; a taken branch overrides any stall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      RUN, LDSTALL: begin
        if (bus.ex_branch_taken) begin
          flush   = 1'b1;
          state_d = RUN;
        end else if (hazard) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          state_d  = LDSTALL;
        end else begin
          state_d = RUN;
          if (state_q == RUN && bus.id_valid && bus.id_hlt) begin
            state_d = HALT_DRAIN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      HALT_DRAIN: begin
        if (bus.ex_branch_taken) begin
          flush   = 1'b1;
          state_d = RUN;
        end else begin
          stall_if = 1'b1;
          if (cnt_q == '0) state_d = HALTED;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      HALTED: begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        halted   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.stall_if  = stall_if;
  assign bus.stall_id  = stall_id;
  assign bus.flush_id  = flush;
  assign bus.flush_ex  = flush;
  assign bus.fwd_a_sel = fwd_a;
  assign bus.fwd_b_sel = fwd_b;
  assign bus.halted    = halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. The bench plays the pipeline:
// it holds ID on stall, inserts bubbles on flush/drain, and predicts the
// controller outputs from a list of in-flight instructions.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int DRAIN = 3;

  typedef struct {
    bit valid;
    int rs;
    int rt;
    bit rsUsed;
    bit rtUsed;
    int rd;
    bit regwrite;
    bit memread;
    bit hlt;
  } instr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.DRAIN_CYC(DRAIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  instr_t pipe [3];
  instr_t held;
  bit     holdNext;
  bit     bubbleNext;
  int     drainLeft;
  bit     haltedM;
  int     vectors;
  int     errors;

  function automatic instr_t bubbleInstr();
    instr_t i;
    i = '{valid: 1'b0, rs: 0, rt: 0, rsUsed: 1'b0, rtUsed: 1'b0,
          rd: 0, regwrite: 1'b0, memread: 1'b0, hlt: 1'b0};
    return i;
  endfunction

  function automatic instr_t mk(int rd, int rs, int rt, bit ru, bit tu,
                                bit rw, bit mr, bit h);
    instr_t i;
    i = '{valid: 1'b1, rs: rs, rt: rt, rsUsed: ru, rtUsed: tu,
          rd: rd, regwrite: rw, memread: mr, hlt: h};
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    i.valid    = ($urandom_range(0, 99) < 85);
    i.hlt      = i.valid && ($urandom_range(0, 99) < 3);
    i.rs       = int'($urandom_range(0, 3));
    i.rt       = int'($urandom_range(0, 3));
    i.rd       = int'($urandom_range(0, 3));
    i.rsUsed   = i.valid && !i.hlt && ($urandom_range(0, 1) == 1);
    i.rtUsed   = i.valid && !i.hlt && ($urandom_range(0, 1) == 1);
    i.memread  = i.valid && !i.hlt && ($urandom_range(0, 99) < 30);
    i.regwrite = i.memread || (i.valid && !i.hlt && ($urandom_range(0, 99) < 70));
    return i;
  endfunction

  // Does in-flight instruction e produce register src (R0 never counts)?
  function automatic bit writes(instr_t e, int src);
    return e.valid && e.regwrite && (e.rd == src) && (src != 0);
  endfunction

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) pipe[k] = bubbleInstr();
    held       = bubbleInstr();
    holdNext   = 1'b0;
    bubbleNext = 1'b0;
    drainLeft  = 0;
    haltedM    = 1'b0;
  endtask

  task automatic driveId(input instr_t i, input bit br);
    bus.id_valid        = i.valid;
    bus.id_rs           = REG_W'(i.rs);
    bus.id_rt           = REG_W'(i.rt);
    bus.id_rs_used      = i.rsUsed;
    bus.id_rt_used      = i.rtUsed;
    bus.id_rd           = REG_W'(i.rd);
    bus.id_regwrite     = i.regwrite;
    bus.id_memread      = i.memread;
    bus.id_hlt          = i.hlt;
    bus.ex_branch_taken = br;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_stall_if"}, int'(bus.stall_if), 0);
    checkOutput({pfx, "_stall_id"}, int'(bus.stall_id), 0);
    checkOutput({pfx, "_flush_id"}, int'(bus.flush_id), 0);
    checkOutput({pfx, "_flush_ex"}, int'(bus.flush_ex), 0);
    checkOutput({pfx, "_fwd_a"},    int'(bus.fwd_a_sel), 0);
    checkOutput({pfx, "_fwd_b"},    int'(bus.fwd_b_sel), 0);
    checkOutput({pfx, "_halted"},   int'(bus.halted), 0);
  endtask

  // One pipeline cycle: called just after a rising edge, returns just after the next
  task automatic applyStimulus(input instr_t fresh, input bit brReq);
    instr_t id;
    bit br, hz, needRs, needRt, hltGo;
    int eSIf, eSId, eFl, eH, fa, fb;

    if (haltedM || drainLeft > 0 || bubbleNext) id = bubbleInstr();
    else if (holdNext)                          id = held;
    else                                        id = fresh;
    br = brReq && pipe[0].valid && !haltedM;
    driveId(id, br);

    @(negedge clk);
    needRs = id.valid && id.rsUsed && id.rs != 0;
    needRt = id.valid && id.rtUsed && id.rt != 0;
`ifdef PIPE_FWD_EN
    hz = pipe[0].memread && ((needRs && writes(pipe[0], id.rs)) ||
                             (needRt && writes(pipe[0], id.rt)));
    fa = writes(pipe[1], pipe[0].rs) ? 1 : (writes(pipe[2], pipe[0].rs) ? 2 : 0);
    fb = writes(pipe[1], pipe[0].rt) ? 1 : (writes(pipe[2], pipe[0].rt) ? 2 : 0);
`else
    hz = (needRs && (writes(pipe[0], id.rs) || writes(pipe[1], id.rs))) ||
         (needRt && (writes(pipe[0], id.rt) || writes(pipe[1], id.rt)));
    fa = 0;
    fb = 0;
`endif
    eSIf = 0; eSId = 0; eFl = 0; eH = 0;
    if (haltedM) begin
      eSIf = 1; eSId = 1; eH = 1;
    end else if (drainLeft > 0) begin
      if (br) eFl = 1;
      else    eSIf = 1;
    end else if (br) begin
      eFl = 1;
    end else if (hz) begin
      eSIf = 1; eSId = 1;
    end
    checkOutput("stall_if", int'(bus.stall_if),  eSIf);
    checkOutput("stall_id", int'(bus.stall_id),  eSId);
    checkOutput("flush_id", int'(bus.flush_id),  eFl);
    checkOutput("flush_ex", int'(bus.flush_ex),  eFl);
    checkOutput("fwd_a",    int'(bus.fwd_a_sel), fa);
    checkOutput("fwd_b",    int'(bus.fwd_b_sel), fb);
    checkOutput("halted",   int'(bus.halted),    eH);

    @(posedge clk);
    hltGo = !haltedM && drainLeft == 0 && !br && !hz && id.valid && id.hlt;
    if (drainLeft > 0) begin
      if (br) drainLeft = 0;
      else begin
        drainLeft--;
        if (drainLeft == 0) haltedM = 1'b1;
      end
    end else if (hltGo) begin
      drainLeft = DRAIN;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = id;
    if (eSId != 0 || eFl != 0) pipe[0].valid = 1'b0;
    held       = id;
    holdNext   = (eSId != 0);
    bubbleNext = (eFl != 0);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, then release away from the edge
  task automatic doReset(input int holdCycles);
    #2;
    rst_n = 1'b0;
    driveId(bubbleInstr(), 1'b0);
    #1;
    checkAllZero("rst");
    modelReset();
    repeat (holdCycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  instr_t nop;
  int     haltedCycles;

  initial begin
    vectors = 0;
    errors  = 0;
    nop     = bubbleInstr();
    modelReset();
    driveId(nop, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed sequences");
    // ADD R3,R1,R2 ; ADD R4,R3,R1
    applyStimulus(mk(3, 1, 2, 1, 1, 1, 0, 0), 1'b0);
    applyStimulus(mk(4, 3, 1, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) applyStimulus(nop, 1'b0);
    // ADD R3 ; NOP ; SUB R5,R1,R3
    applyStimulus(mk(3, 1, 2, 1, 1, 1, 0, 0), 1'b0);
    applyStimulus(nop, 1'b0);
    applyStimulus(mk(5, 1, 3, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) applyStimulus(nop, 1'b0);
    // same, middle op also writes R3
    applyStimulus(mk(3, 1, 2, 1, 1, 1, 0, 0), 1'b0);
    applyStimulus(mk(3, 2, 2, 1, 1, 1, 0, 0), 1'b0);
    applyStimulus(mk(5, 1, 3, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) applyStimulus(nop, 1'b0);
    // LW R3 ; ADD R4,R3,R3
    applyStimulus(mk(3, 1, 0, 1, 0, 1, 1, 0), 1'b0);
    applyStimulus(mk(4, 3, 3, 1, 1, 1, 0, 0), 1'b0);
    repeat (4) applyStimulus(nop, 1'b0);
    // R0 producer/consumer
    applyStimulus(mk(0, 1, 2, 1, 1, 1, 0, 0), 1'b0);
    applyStimulus(mk(1, 0, 0, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) applyStimulus(nop, 1'b0);
    // HLT drains to HALTED, then reset while halted
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), 1'b0);
    repeat (6) applyStimulus(nop, 1'b0);
    doReset(2);
    applyStimulus(mk(3, 1, 2, 1, 1, 1, 0, 0), 1'b0);
    applyStimulus(mk(4, 3, 1, 1, 1, 1, 0, 0), 1'b0);
    // HLT then branch taken in the first drain cycle
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1), 1'b0);
    applyStimulus(nop, 1'b1);
    repeat (6) applyStimulus(nop, 1'b0);
    // reset during the load-use stall window; no stale hazard afterwards
    applyStimulus(mk(3, 1, 0, 1, 0, 1, 1, 0), 1'b0);
    applyStimulus(mk(4, 3, 3, 1, 1, 1, 0, 0), 1'b0);
    doReset(1);
    applyStimulus(mk(4, 3, 3, 1, 1, 1, 0, 0), 1'b0);
    repeat (3) applyStimulus(nop, 1'b0);

    $display("[TB] random sequence");
    haltedCycles = 0;
    for (int n = 0; n < 3000; n++) begin
      if (haltedM) haltedCycles++;
      else         haltedCycles = 0;
      if (haltedCycles > 4 || $urandom_range(0, 199) == 0) begin
        doReset(int'($urandom_range(1, 3)));
        haltedCycles = 0;
      end else begin
        applyStimulus(randInstr(), ($urandom_range(0, 9) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
